alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle add/sub/logic/shift and
// iterative shift-add multiply and restoring divide.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request strobe, accepted when the unit can take a new operation
//   s     - op select: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 mul, 7 div
//   a, b  - unsigned operands (WIDTH bits)
//   y     - registered 2*WIDTH result, held until the next completion
//   busy  - high while mul/div iterates
//   done  - one-cycle pulse with each new y
//   dbz   - divide-by-zero flag, updated with y
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         s,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               dbz
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e state_q, state_d;

  logic               go_q;      // an accepted operation launches this cycle
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] y_q;
  logic               dbz_q;

  logic               is_multi;
  logic               accept;
  logic               last_step;
  logic [2*WIDTH-1:0] single_res;
  logic [2*WIDTH-1:0] step_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_rem;
  logic               div_ge;
  logic [32:0]        b_ext;

  assign is_multi  = (op_q[2:1] == 2'b11);
  assign last_step = (cnt_q == CntW'(WIDTH - 1));
  // The launch cycle of a mul/div is treated like busy so the latched
  // operands cannot be overwritten before iteration starts.
  assign accept    = start && (state_q != StIter) && !(go_q && is_multi);
  assign b_ext     = 33'(b_q);

  // Single-cycle results from the latched operands.
  always_comb begin
    single_res = '0;
    unique case (op_q)
      3'd0: single_res = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      3'd1: single_res = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
      3'd2: single_res = {{WIDTH{1'b0}}, a_q & b_q};
      3'd3: single_res = {{WIDTH{1'b0}}, a_q | b_q};
      3'd4: single_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      3'd5: begin
        if (b_ext >= 33'(2 * WIDTH)) single_res = '0;
        else                         single_res = {{WIDTH{1'b0}}, a_q} << b_q;
      end
      default: single_res = '0;
    endcase
  end

  // One iteration step. acc_q holds {hi, multiplier} for mul and
  // {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_tmp = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_tmp >= {1'b0, b_q});
    div_rem = div_ge ? (div_tmp - {1'b0, b_q}) : div_tmp;
    if (op_q[0]) step_res = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    else         step_res = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (go_q) state_d = is_multi ? StIter : StDone;
        else      state_d = StIdle;
      end
      StIter:  state_d = last_step ? StDone : StIter;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_q == StIter);
    done = (state_q == StDone);
    y    = y_q;
    dbz  = dbz_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q  <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      go_q <= accept;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= s;
      end
      if (go_q) begin
        if (is_multi) begin
          acc_q <= op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, b_q};
          cnt_q <= '0;
        end else begin
          y_q   <= single_res;
          dbz_q <= 1'b0;
        end
      end else if (state_q == StIter) begin
        acc_q <= step_res;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          y_q   <= step_res;
          dbz_q <= op_q[0] && (b_q == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     s;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] y;
  logic           busy, done, dbz;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .s    (s),
    .a    (a),
    .b    (b),
    .y    (y),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] ia,
                                           input logic [W-1:0] ib);
    longint unsigned ua, ub, r, m;
    ua = longint'(ia);
    ub = longint'(ib);
    m  = (64'd1 << (2 * W)) - 1;
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = (ua - ub) & m;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (ub >= 2 * W) ? 0 : ((ua << ub) & m);
      3'd6: r = ua * ub;
      default: r = (ub == 0) ? ((ua << W) | ((64'd1 << W) - 1)) : (((ua % ub) << W) | (ua / ub));
    endcase
    return r[2*W-1:0];
  endfunction

  // Issue one op, check latency, busy duration, result, flag and done width.
  // poke raises a second start mid-iteration to confirm it is ignored.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit poke, input logic [2*W-1:0] exp_y, input bit exp_dbz);
    int lat, busy_cyc, extra;
    int exp_lat, exp_busy;
    exp_lat  = (op >= 3'd6) ? W + 1 : 1;
    exp_busy = (op >= 3'd6) ? W : 0;
    @(negedge clk);
    s = op; a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0; busy_cyc = 0;
    while (!done && lat < W + 6) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
      start = poke && (lat == 2);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
    check("busy_at_done", 64'(busy), 64'd0);
    check("y", 64'(y), 64'(exp_y));
    check("dbz", 64'(dbz), 64'(exp_dbz));
    @(posedge clk); #1;
    check("done_width", 64'(done), 64'd0);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < W + 3; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check("ignored_start_dones", 64'(extra), 64'd0);
    end
  endtask

  task automatic run_rand(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib);
    run_op(op, ia, ib, 1'b0, ref_y(op, ia, ib), (op == 3'd7) && (ib == '0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; s = '0; a = '0; b = '0;
    #1;
    check("rst_y", 64'(y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    run_op(3'd0, 4'd9, 4'd8, 1'b0, 8'h11, 1'b0);
    run_op(3'd1, 4'd3, 4'd5, 1'b0, 8'hFE, 1'b0);
    run_op(3'd5, 4'hA, 4'd3, 1'b0, 8'h50, 1'b0);
    run_op(3'd5, 4'h1, 4'd8, 1'b0, 8'h00, 1'b0);
    run_op(3'd6, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0);
    run_op(3'd6, 4'd15, 4'd15, 1'b1, 8'hE1, 1'b0);
    run_op(3'd7, 4'd13, 4'd4, 1'b0, 8'h13, 1'b0);
    run_op(3'd7, 4'd7, 4'd0, 1'b0, 8'h7F, 1'b1);
    run_op(3'd0, 4'd1, 4'd2, 1'b0, 8'h03, 1'b0);

    // Back-to-back single-cycle ops with start held high.
    @(negedge clk);
    s = 3'd4; a = 4'hC; b = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    s = 3'd2; a = 4'hE; b = 4'h7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_y1", 64'(y), 64'h09);
    @(posedge clk); #1;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_y2", 64'(y), 64'h06);
    @(posedge clk); #1;
    check("b2b_idle", 64'(done), 64'd0);

    // Reset during the second iteration cycle of a multiply.
    run_op(3'd0, 4'hF, 4'hF, 1'b0, 8'h1E, 1'b0);
    @(negedge clk);
    s = 3'd6; a = 4'd9; b = 4'd11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("abort_y", 64'(y), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    @(negedge clk); rst = 1'b0;
    d = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done) d++;
    end
    check("abort_no_done", 64'(d), 64'd0);
    run_op(3'd0, 4'd6, 4'd7, 1'b0, 8'h0D, 1'b0);

    // Randomized ops, with zero divisors and large shifts forced in often.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom);
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_rand(rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
